// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser, 4-state Moore FSM,
// sticky pending flags and a saturating total event counter.
module edge_detect_multi #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     level,
  input  logic [2*N-1:0]   mode,
  input  logic [N-1:0]     clr,
  input  logic             cnt_clr,
  output logic [N-1:0]     tick,
  output logic [N-1:0]     pending,
  output logic             any_pending,
  output logic [CNT_W-1:0] edge_count
);

  typedef enum logic [1:0] {ZERO, RISE, ONE, FALL} state_t;

  // Six spare bits hold a popcount of up to 32 ticks without overflow.
  localparam int SW = CNT_W + 6;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  logic [N-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = level;
    end else begin : g_sync
      logic [N-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= level;
          for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  function automatic state_t next_state(input state_t cur, input logic sv);
    state_t nxt;
    case (cur)
      ZERO:    nxt = sv ? RISE : ZERO;
      RISE:    nxt = sv ? ONE  : FALL;
      ONE:     nxt = sv ? ONE  : FALL;
      FALL:    nxt = sv ? RISE : ZERO;
      default: nxt = ZERO;
    endcase
    return nxt;
  endfunction

  state_t st [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) st[i] <= ZERO;
    end else begin
      for (int unsigned i = 0; i < N; i++) st[i] <= next_state(st[i], s[i]);
    end
  end

  // Mode gates the decode only, so a mode change never disturbs tracking.
  always_comb begin
    tick = '0;
    for (int unsigned i = 0; i < N; i++) begin
      tick[i] = ((st[i] == RISE) && mode[2*i]) || ((st[i] == FALL) && mode[2*i+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= tick | (pending & ~clr);
  end

  assign any_pending = |pending;

  logic [SW-1:0] pc;
  logic [SW-1:0] sum;

  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < N; i++) pc = pc + SW'(tick[i]);
    sum = SW'(edge_count) + pc;
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr)  edge_count <= '0;
    else if (sum > CNT_MAX) edge_count <= '1;
    else                    edge_count <= sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboard bench for edge_detect_multi (N=4, SYNC_STAGES=2, CNT_W=4).
module tb_edge_detect_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] level = '0;
  logic [7:0] mode = '0;
  logic [3:0] clr = '0;
  logic       cnt_clr = 1'b0;
  logic [3:0] tick;
  logic [3:0] pending;
  logic       any_pending;
  logic [3:0] edge_count;

  edge_detect_multi #(.N(4), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .level(level), .mode(mode), .clr(clr),
    .cnt_clr(cnt_clr), .tick(tick), .pending(pending),
    .any_pending(any_pending), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] p;
    logic       a;
    logic [3:0] c;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference: level history h1 (newest sample) .. h4; an edge is seen by the
  // tick two edges after it is sampled, so tick reflects h3 versus h4.
  logic [3:0] h1 = '0, h2 = '0, h3 = '0, h4 = '0;
  logic [3:0] mpend = '0;
  logic [3:0] mtick = '0;
  int mcnt = 0;

  task automatic step(input logic [3:0] lv, input logic [7:0] md, input logic [3:0] cl,
                      input logic cc, input logic rs);
    exp_t e;
    logic [3:0] mr, mf, tnow;
    for (int i = 0; i < 4; i++) begin
      mr[i] = md[2*i];
      mf[i] = md[2*i+1];
    end
    tnow = ((h3 & ~h4) & mr) | ((~h3 & h4) & mf);
    if (rs) begin
      h1 = '0; h2 = '0; h3 = '0; h4 = '0;
      mpend = '0;
      mcnt = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (tnow[i]) mpend[i] = 1'b1;
        else if (cl[i]) mpend[i] = 1'b0;
      end
      if (cc) mcnt = 0;
      else begin
        mcnt = mcnt + $countones(tnow);
        if (mcnt > 15) mcnt = 15;
      end
      h4 = h3; h3 = h2; h2 = h1; h1 = lv;
    end
    mtick = ((h3 & ~h4) & mr) | ((~h3 & h4) & mf);
    e.t = mtick;
    e.p = mpend;
    e.a = |mpend;
    e.c = 4'(mcnt);
    sbq.push_back(e);
    level = lv; mode = md; clr = cl; cnt_clr = cc; reset = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      step(4'($urandom), 8'hFF, 4'hF, 1'b0, 1'b1);
      e = sbq.pop_front();
      n_checks += 4;
      if (tick !== e.t) begin n_fail++; $display("FAIL reset_tick got %b want %b", tick, e.t); end
      if (pending !== e.p) begin n_fail++; $display("FAIL reset_pending got %b want %b", pending, e.p); end
      if (any_pending !== e.a) begin n_fail++; $display("FAIL reset_any got %b want %b", any_pending, e.a); end
      if (edge_count !== e.c) begin n_fail++; $display("FAIL reset_count got %0d want %0d", edge_count, e.c); end
    end
  endtask

  task automatic test_single_rise();
    exp_t e;
    logic [3:0] lv;
    for (int k = 0; k < 14; k++) begin
      lv = (k >= 4 && k < 10) ? 4'b0001 : 4'b0000;
      step(lv, 8'h55, 4'h0, k == 0, 1'b0);
      e = sbq.pop_front();
      n_checks += 3;
      if (tick !== e.t) begin n_fail++; $display("FAIL rise_tick cyc %0d got %b want %b", k, tick, e.t); end
      if (pending[0] !== e.p[0]) begin n_fail++; $display("FAIL rise_pending cyc %0d got %b want %b", k, pending[0], e.p[0]); end
      if (edge_count !== e.c) begin n_fail++; $display("FAIL rise_count cyc %0d got %0d want %0d", k, edge_count, e.c); end
    end
    n_checks++;
    if (edge_count !== 4'd1) begin n_fail++; $display("FAIL rise_final_count got %0d want 1", edge_count); end
  endtask

  task automatic test_pulse_both();
    exp_t e;
    int seen = 0;
    for (int k = 0; k < 10; k++) begin
      step((k == 4) ? 4'b0001 : 4'b0000, 8'h03, 4'h0, k == 0, 1'b0);
      e = sbq.pop_front();
      if (tick[0]) seen++;
      n_checks += 2;
      if (tick !== e.t) begin n_fail++; $display("FAIL pulse_tick cyc %0d got %b want %b", k, tick, e.t); end
      if (edge_count !== e.c) begin n_fail++; $display("FAIL pulse_count cyc %0d got %0d want %0d", k, edge_count, e.c); end
    end
    n_checks += 2;
    if (seen != 2) begin n_fail++; $display("FAIL pulse_tick_cycles got %0d want 2", seen); end
    if (edge_count !== 4'd2) begin n_fail++; $display("FAIL pulse_final_count got %0d want 2", edge_count); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int all_seen = 0;
    for (int k = 0; k < 13; k++) begin
      step((k >= 4 && k < 9) ? 4'hF : 4'h0, 8'h55, 4'h0, k == 0, 1'b0);
      e = sbq.pop_front();
      if (tick === 4'hF) all_seen++;
      n_checks += 2;
      if (tick !== e.t) begin n_fail++; $display("FAIL simul_tick cyc %0d got %b want %b", k, tick, e.t); end
      if (edge_count !== e.c) begin n_fail++; $display("FAIL simul_count cyc %0d got %0d want %0d", k, edge_count, e.c); end
    end
    n_checks += 2;
    if (all_seen != 1) begin n_fail++; $display("FAIL simul_all_cycles got %0d want 1", all_seen); end
    if (edge_count !== 4'd4) begin n_fail++; $display("FAIL simul_final_count got %0d want 4", edge_count); end
  endtask

  task automatic test_saturation();
    exp_t e;
    int guard;
    for (int k = 0; k < 44; k++) begin
      step((k < 40 && k[0] == 1'b0) ? 4'b0001 : 4'b0000, 8'h01, 4'h0, k == 0, 1'b0);
      e = sbq.pop_front();
      n_checks++;
      if (edge_count !== e.c) begin n_fail++; $display("FAIL sat_count cyc %0d got %0d want %0d", k, edge_count, e.c); end
    end
    n_checks++;
    if (edge_count !== 4'd15) begin n_fail++; $display("FAIL sat_final_count got %0d want 15", edge_count); end
    step(4'b0001, 8'h01, 4'h0, 1'b0, 1'b0);
    void'(sbq.pop_front());
    guard = 0;
    while (mtick[0] !== 1'b1 && guard < 6) begin
      step(4'b0000, 8'h01, 4'h0, 1'b0, 1'b0);
      void'(sbq.pop_front());
      guard++;
    end
    n_checks++;
    if (tick[0] !== 1'b1) begin n_fail++; $display("FAIL sat_tick_before_clr got %b want 1", tick[0]); end
    step(4'b0000, 8'h01, 4'h0, 1'b1, 1'b0);
    e = sbq.pop_front();
    n_checks += 2;
    if (edge_count !== e.c) begin n_fail++; $display("FAIL sat_clr_count got %0d want %0d", edge_count, e.c); end
    if (edge_count !== 4'd0) begin n_fail++; $display("FAIL sat_clr_zero got %0d want 0", edge_count); end
  endtask

  task automatic test_clr();
    exp_t e;
    int guard;
    for (int k = 0; k < 3; k++) begin
      step(4'h0, 8'h10, 4'hF, 1'b1, 1'b0);
      e = sbq.pop_front();
      n_checks++;
      if (pending !== e.p) begin n_fail++; $display("FAIL clr_flush got %b want %b", pending, e.p); end
    end
    step(4'b0100, 8'h10, 4'h0, 1'b0, 1'b0);
    void'(sbq.pop_front());
    guard = 0;
    while (mtick[2] !== 1'b1 && guard < 6) begin
      step(4'b0100, 8'h10, 4'h0, 1'b0, 1'b0);
      void'(sbq.pop_front());
      guard++;
    end
    n_checks++;
    if (tick[2] !== 1'b1) begin n_fail++; $display("FAIL clr_tick got %b want 1", tick[2]); end
    step(4'b0100, 8'h10, 4'b0100, 1'b0, 1'b0);
    e = sbq.pop_front();
    n_checks += 2;
    if (pending !== e.p) begin n_fail++; $display("FAIL clr_set_wins got %b want %b", pending, e.p); end
    if (pending[2] !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins_bit got %b want 1", pending[2]); end
    step(4'b0100, 8'h10, 4'b0100, 1'b0, 1'b0);
    e = sbq.pop_front();
    n_checks += 3;
    if (pending !== e.p) begin n_fail++; $display("FAIL clr_cleared got %b want %b", pending, e.p); end
    if (pending[2] !== 1'b0) begin n_fail++; $display("FAIL clr_cleared_bit got %b want 0", pending[2]); end
    if (any_pending !== 1'b0) begin n_fail++; $display("FAIL clr_any got %b want 0", any_pending); end
  endtask

  task automatic test_reset_level();
    exp_t e;
    logic [7:0] md;
    for (int pass = 0; pass < 2; pass++) begin
      md = (pass == 0) ? 8'h40 : 8'h00;
      step(4'h0, md, 4'hF, 1'b1, 1'b0);
      void'(sbq.pop_front());
      for (int k = 0; k < 10; k++) begin
        step(4'b1000, md, 4'h0, 1'b0, k < 3);
        e = sbq.pop_front();
        n_checks += 3;
        if (tick !== e.t) begin n_fail++; $display("FAIL rstlvl_tick pass %0d cyc %0d got %b want %b", pass, k, tick, e.t); end
        if (pending !== e.p) begin n_fail++; $display("FAIL rstlvl_pending pass %0d cyc %0d got %b want %b", pass, k, pending, e.p); end
        if (edge_count !== e.c) begin n_fail++; $display("FAIL rstlvl_count pass %0d cyc %0d got %0d want %0d", pass, k, edge_count, e.c); end
      end
      n_checks++;
      if (edge_count !== ((pass == 0) ? 4'd1 : 4'd0)) begin
        n_fail++;
        $display("FAIL rstlvl_final_count pass %0d got %0d want %0d", pass, edge_count, (pass == 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_pulse_both();
    test_simultaneous();
    test_saturation();
    test_clr();
    test_reset_level();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
